// File: rtl/button_event_gen.sv
// Two independent button channels: synchronize, debounce, classify short/long
// presses and stretch each event so a slow (1 Hz) consumer can sample it.

module button_event_stretch #(
    parameter int HOLD_CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic fire,
    output logic pulse
);
    localparam int HW = $clog2(HOLD_CYCLES) + 1;

    logic [HW-1:0] hold_cnt;

    // A fire while already high simply reloads, so the pulse has no gap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pulse    <= 1'b0;
            hold_cnt <= '0;
        end else if (fire) begin
            pulse    <= 1'b1;
            hold_cnt <= HW'(HOLD_CYCLES);
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HW'(1);
            pulse    <= (hold_cnt != HW'(1));
        end else begin
            pulse <= 1'b0;
        end
    end
endmodule

module button_event_channel #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 100_000_000,
    parameter int HOLD_CYCLES     = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic ev_short,
    output logic ev_long
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int LW = $clog2(LONG_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, PRESS, LONG_WAIT} press_state_t;

    logic          sync1, sync2, level, flip;
    logic [DW-1:0] deb_cnt;
    logic [LW-1:0] press_cnt, press_cnt_next;
    logic          fire_short, fire_long;
    press_state_t  state, state_next;

    // flip marks the edge on which the debounced level changes.
    assign flip = (sync2 != level) && (deb_cnt == DW'(DEBOUNCE_CYCLES));

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            deb_cnt <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            if (sync2 == level) begin
                deb_cnt <= '0;
            end else if (flip) begin
                level   <= ~level;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            press_cnt <= '0;
        end else begin
            state     <= state_next;
            press_cnt <= press_cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        press_cnt_next = press_cnt;
        fire_short     = 1'b0;
        fire_long      = 1'b0;
        case (state)
            IDLE: begin
                if (flip && !level) begin
                    state_next     = PRESS;
                    press_cnt_next = '0;
                end
            end
            PRESS: begin
                if (!level) begin
                    state_next = IDLE;
                    fire_short = 1'b1;
                end else if (press_cnt == LW'(LONG_CYCLES - 1)) begin
                    state_next = LONG_WAIT;
                    fire_long  = 1'b1;
                end else begin
                    press_cnt_next = press_cnt + LW'(1);
                end
            end
            LONG_WAIT: begin
                if (!level) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    button_event_stretch #(.HOLD_CYCLES(HOLD_CYCLES)) u_short (
        .clk   (clk),
        .rst   (rst),
        .fire  (fire_short),
        .pulse (ev_short)
    );

    button_event_stretch #(.HOLD_CYCLES(HOLD_CYCLES)) u_long (
        .clk   (clk),
        .rst   (rst),
        .fire  (fire_long),
        .pulse (ev_long)
    );
endmodule

module button_event_gen #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 100_000_000,
    parameter int HOLD_CYCLES     = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn0,
    input  logic btn1,
    output logic b0short,
    output logic b0long,
    output logic b1short,
    output logic b1long
);
    button_event_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .LONG_CYCLES     (LONG_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES)
    ) u_ch0 (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn0),
        .ev_short (b0short),
        .ev_long  (b0long)
    );

    button_event_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .LONG_CYCLES     (LONG_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES)
    ) u_ch1 (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn1),
        .ev_short (b1short),
        .ev_long  (b1long)
    );
endmodule

// File: doc/button_event_gen.md
# button_event_gen

Turns the two raw push-buttons into the debounced, classified press events that the clock/alarm mode blocks consume: b0short, b0long, b1short and b1long. Each event output is held high long enough that a consumer sampling on the slow 1 Hz clock sees it. It sits between the board button pins and the mode logic, one instance serving all modes.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles needed to accept a level change (10 ms at 100 MHz).
- LONG_CYCLES, 100_000_000: debounced hold time that makes a press "long" (1 s).
- HOLD_CYCLES, 100_000_000: cycles each event output stays high; must be at least one consumer clock period.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset; synchronous and active-low.
- btn0  in  1  raw button 0, active-high, asynchronous to clk.
- btn1  in  1  raw button 1, active-high, asynchronous to clk.
- b0short  out  1  short press of button 0 (stretched pulse).
- b0long  out  1  long press of button 0 (stretched pulse).
- b1short  out  1  short press of button 1 (stretched pulse).
- b1long  out  1  long press of button 1 (stretched pulse).

## Operation
- Two identical, fully independent channels, one per button. Each channel has:
  - a 2-flop synchronizer;
  - a debouncer;
  - a press FSM;
  - two output stretchers.
- Debouncer:
  - The debounced level starts at 0.
  - A counter runs while the synced input differs from the debounced level, and clears to 0 whenever they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
- Press FSM states: IDLE, PRESS, LONG_WAIT.
  - IDLE -> PRESS on a debounced rise; the press counter loads 0.
  - PRESS: the press counter increments every cycle while the debounced level is high.
  - PRESS -> LONG_WAIT when the counter reaches LONG_CYCLES-1 with the level still high; this fires the long event.
  - PRESS -> IDLE on a debounced fall before that point; this fires the short event.
  - LONG_WAIT -> IDLE on a debounced fall; no event fires.
  - A press therefore produces exactly one event: short or long, never both.
- Stretcher, one per output:
  - A fire sets the output to 1 and loads HOLD_CYCLES into its down-counter.
  - The counter decrements every cycle; the output clears when it reaches 0.
  - A fire while the output is already high reloads the counter, so the output stays high continuously with no gap.
- Counter widths: $clog2 of the respective parameter plus 1. Counters saturate and never wrap.
- Reset (rst==0 at a clk edge):
  - All outputs go to 0, all FSMs to IDLE, and all counters, synchronizers and debounced levels to 0.
  - This takes effect on that edge, including in the middle of a press or a hold.
  - A button still held when rst returns high is seen as a fresh press after synchronization and debounce.

## Timing
- All outputs are registered and are 0 out of reset.
- Press acceptance latency: a debounced rise occurs 2 + DEBOUNCE_CYCLES cycles after the first edge that samples btn high, given btn stays high throughout.
- Long event: the output rises LONG_CYCLES cycles after the debounced rise, while the button is still held.
- Short event: the output rises 1 cycle after the debounced fall. The fall occurs 2 + DEBOUNCE_CYCLES cycles after btn goes low.
- Every event output is high for exactly HOLD_CYCLES cycles, unless re-fired or reset.
- Glitches: a raw pulse or dropout shorter than DEBOUNCE_CYCLES synced cycles produces no level change and no event.
- Simultaneous events: both channels may fire on the same cycle; there is no arbitration and no cross-coupling.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, LONG_CYCLES=20, HOLD_CYCLES=8.
- Reset: hold rst=0 for 3 cycles with both buttons high -> all four outputs are 0 throughout; after rst=1, b0/b1 events appear only per normal timing.
- Short press: btn0 high for 12 cycles then low -> b0short high for exactly 8 cycles, starting 2+4+1 = 7 cycles after release; b0long stays 0.
- Long press: btn1 high for 40 cycles -> b1long rises 26 cycles after btn1 rises (2+4+20) and stays high for 8 cycles; no b1short on release.
- Glitch rejection: btn0 high for 3 cycles, then low; repeat 5 times with 3-cycle gaps -> no output ever asserts.
- Independence: btn0 short press overlapping a btn1 long press -> b0short and b1long each match their standalone timing exactly.
- Reset mid-hold: assert rst=0 on the 3rd cycle of a b0short hold -> b0short is 0 at that edge; no residual pulse after rst=1 with the button released.
